// File: rtl/hsv_to_rgb.sv
// HSV to RGB converter. Q16.16 H/S/V in, 8-bit R/G/B (zero-extended to 32 bits) out.
// Fixed 19-cycle latency: PREP, 16 DIV cycles, MIX, SCALE.
module hsv_to_rgb (
    input  logic        clk,
    input  logic        rst,
    input  logic [95:0] In,
    input  logic        In_Valid,
    output logic        Ready,
    input  logic        Enable,
    output wire  [95:0] Out,
    output logic        Valid_Out,
    output logic        Error
);
    localparam logic [31:0] Sixty  = 32'h003C0000;
    localparam logic [31:0] HueMax = 32'h01680000;
    localparam logic [31:0] One    = 32'h00010000;

    typedef enum logic [2:0] {StIdle, StPrep, StDiv, StMix, StScale} state_t;

    state_t      state_q, state_d;
    logic [95:0] in_q;
    logic [31:0] c_q, x_q, m_q;
    logic [2:0]  k_q;
    logic [32:0] rem_q;
    logic [15:0] quo_q;
    logic [3:0]  cnt_q;
    logic        err_q;
    logic [95:0] out_q;
    logic        valid_q;
    logic        err_out_q;

    logic [31:0] h, s, v;
    assign h = in_q[95:64];
    assign s = in_q[63:32];
    assign v = in_q[31:0];

    // PREP: chroma, hue sector, remainder within sector, range check
    logic [63:0] vs_prod;
    logic [2:0]  k_c;
    logic [31:0] hrem_c;
    logic        range_err;
    always_comb begin
        vs_prod = {32'd0, v} * {32'd0, s};
        k_c = 3'd0;
        if (h >= 32'h003C0000) k_c = 3'd1;
        if (h >= 32'h00780000) k_c = 3'd2;
        if (h >= 32'h00B40000) k_c = 3'd3;
        if (h >= 32'h00F00000) k_c = 3'd4;
        if (h >= 32'h012C0000) k_c = 3'd5;
        hrem_c    = h - (32'(k_c) * Sixty);
        range_err = (h >= HueMax) || (s > One) || (v > One);
    end

    // DIV: one restoring-division step, dividend pre-shifted by 16 via the iterations
    logic [32:0] rem_sh;
    logic        q_bit;
    logic [32:0] rem_next;
    always_comb begin
        rem_sh   = {rem_q[31:0], 1'b0};
        q_bit    = (rem_sh >= {1'b0, Sixty});
        rem_next = q_bit ? (rem_sh - {1'b0, Sixty}) : rem_sh;
    end

    // MIX: odd sectors ramp downward, so use the complement of the fraction
    logic [16:0] f_eff;
    logic [63:0] cx_prod;
    always_comb begin
        f_eff   = k_q[0] ? (17'h10000 - {1'b0, quo_q}) : {1'b0, quo_q};
        cx_prod = {32'd0, c_q} * {47'd0, f_eff};
    end

    function automatic logic [31:0] scale(input logic [31:0] ch, input logic [31:0] m);
        logic [63:0] t;
        t = ((({32'd0, ch} + {32'd0, m}) * 64'd255) + 64'h8000) >> 16;
        return (t > 64'd255) ? 32'd255 : t[31:0];
    endfunction

    // SCALE: map (C, X, 0) to channels by sector and scale to 0..255
    logic [31:0] cs, xs, zs;
    logic [31:0] r_c, g_c, b_c;
    always_comb begin
        cs  = scale(c_q, m_q);
        xs  = scale(x_q, m_q);
        zs  = scale(32'd0, m_q);
        r_c = cs;
        g_c = zs;
        b_c = xs;
        case (k_q)
            3'd0:    begin r_c = cs; g_c = xs; b_c = zs; end
            3'd1:    begin r_c = xs; g_c = cs; b_c = zs; end
            3'd2:    begin r_c = zs; g_c = cs; b_c = xs; end
            3'd3:    begin r_c = zs; g_c = xs; b_c = cs; end
            3'd4:    begin r_c = xs; g_c = zs; b_c = cs; end
            default: begin r_c = cs; g_c = zs; b_c = xs; end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (In_Valid) state_d = StPrep;
            StPrep:  state_d = StDiv;
            StDiv:   if (cnt_q == 4'd15) state_d = StMix;
            StMix:   state_d = StScale;
            StScale: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath registers advanced by the current state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q      <= '0;
            c_q       <= '0;
            x_q       <= '0;
            m_q       <= '0;
            k_q       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            err_out_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                StIdle: if (In_Valid) in_q <= In;
                StPrep: begin
                    c_q   <= vs_prod[47:16];
                    k_q   <= k_c;
                    rem_q <= {1'b0, hrem_c};
                    err_q <= range_err;
                    quo_q <= '0;
                    cnt_q <= '0;
                end
                StDiv: begin
                    rem_q <= rem_next;
                    quo_q <= {quo_q[14:0], q_bit};
                    cnt_q <= cnt_q + 4'd1;
                end
                StMix: begin
                    x_q <= cx_prod[47:16];
                    m_q <= v - c_q;
                end
                StScale: begin
                    out_q     <= err_q ? 96'd0 : {r_c, g_c, b_c};
                    err_out_q <= err_q;
                    valid_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Ready     = (state_q == StIdle);
    assign Valid_Out = valid_q;
    assign Error     = err_out_q;
    assign Out       = Enable ? out_q : {96{1'bz}};

endmodule

// File: tb/tb_hsv_to_rgb.sv
// Self-checking bench for hsv_to_rgb: directed steps plus a scoreboard of expected results.
module tb_hsv_to_rgb;
    logic        clk = 1'b0;
    logic        rst;
    logic [95:0] in_w;
    logic        in_valid;
    logic        enable;
    wire  [95:0] out_w;
    logic        ready;
    logic        valid_out;
    logic        error;

    always #5 clk = ~clk;

    hsv_to_rgb dut (
        .clk(clk),
        .rst(rst),
        .In(in_w),
        .In_Valid(in_valid),
        .Ready(ready),
        .Enable(enable),
        .Out(out_w),
        .Valid_Out(valid_out),
        .Error(error)
    );

    typedef struct packed {
        logic [95:0] rgb;
        logic        err;
        int unsigned acc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    int          accepts = 0;
    int          aborted = 0;
    int          valids = 0;
    logic        use_ovr = 1'b0;
    logic [95:0] ovr_rgb = '0;
    logic        ovr_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned sc(input longint unsigned ch, input longint unsigned m);
        longint unsigned t;
        t = ((ch + m) * 255 + 32768) >> 16;
        return (t > 255) ? 255 : t;
    endfunction

    // Reference model written straight from the conversion formulas
    function automatic exp_t model(input logic [95:0] x);
        exp_t e;
        longint unsigned h, s, v, c, k, hr, f, xx, m, r, g, b;
        h = 64'(x[95:64]);
        s = 64'(x[63:32]);
        v = 64'(x[31:0]);
        e.acc = 0;
        e.rgb = '0;
        e.err = 1'b0;
        if (h >= 64'h1680000 || s > 64'h10000 || v > 64'h10000) begin
            e.err = 1'b1;
            return e;
        end
        c  = (v * s) >> 16;
        k  = h / 64'h3C0000;
        hr = h - k * 64'h3C0000;
        f  = (hr << 16) / 64'h3C0000;
        xx = (k % 2 == 0) ? ((c * f) >> 16) : ((c * (65536 - f)) >> 16);
        m  = v - c;
        r = c; g = 0; b = xx;
        case (k)
            0: begin r = c;  g = xx; b = 0;  end
            1: begin r = xx; g = c;  b = 0;  end
            2: begin r = 0;  g = c;  b = xx; end
            3: begin r = 0;  g = xx; b = c;  end
            4: begin r = xx; g = 0;  b = c;  end
            default: begin r = c; g = 0; b = xx; end
        endcase
        e.rgb = {32'(sc(r, m)), 32'(sc(g, m)), 32'(sc(b, m))};
        return e;
    endfunction

    // Monitor: push on accept, pop and compare on Valid_Out
    always @(negedge clk) begin
        exp_t e;
        logic z_ok;
        if (!rst) begin
            if (valid_out) begin
                valids++;
                if (sb.size() == 0) begin
                    check("spurious_valid_out", {95'd0, valid_out}, 96'd0);
                end else begin
                    e = sb.pop_front();
                    check("latency", 96'(cyc - e.acc), 96'd19);
                    check("error_flag", {95'd0, error}, {95'd0, e.err});
                    if (enable) begin
                        check("rgb", out_w, e.rgb);
                    end else begin
                        z_ok = (out_w === {96{1'bz}});
                        check("out_highz_at_valid", {95'd0, z_ok}, 96'd1);
                    end
                end
            end
            if (in_valid && ready) begin
                e = use_ovr ? '{rgb: ovr_rgb, err: ovr_err, acc: 0} : model(in_w);
                e.acc = cyc + 1;
                sb.push_back(e);
                accepts++;
            end
        end
    end

    function automatic logic [95:0] rand_in();
        logic [31:0] h, s, v;
        h = $urandom_range(32'h0167FFFF, 0);
        s = $urandom_range(32'h00010000, 0);
        v = $urandom_range(32'h00010000, 0);
        return {h, s, v};
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accept edge
    task automatic start(input logic [95:0] x, input logic ovr, input logic [95:0] rgb,
                         input logic err);
        use_ovr  = ovr;
        ovr_rgb  = rgb;
        ovr_err  = err;
        in_w     = x;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_w     = {$urandom, $urandom, $urandom};
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("completion_timeout", 96'(sb.size()), 96'd0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [95:0] x, input logic [95:0] rgb, input logic err);
        start(x, 1'b1, rgb, err);
        wait_done();
    endtask

    initial begin
        logic z_ok;
        int   acc0;
        logic rdy_exp;
        rst      = 1'b1;
        in_valid = 1'b0;
        enable   = 1'b1;
        in_w     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", {95'd0, ready}, 96'd1);
        check("reset_valid_out", {95'd0, valid_out}, 96'd0);
        check("reset_error", {95'd0, error}, 96'd0);
        check("reset_out", out_w, 96'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Hue sweep at full saturation and value
        run({32'h00000000, 32'h00010000, 32'h00010000}, {32'd255, 32'd0, 32'd0}, 1'b0);
        run({32'h005A0000, 32'h00010000, 32'h00010000}, {32'd128, 32'd255, 32'd0}, 1'b0);
        run({32'h00780000, 32'h00010000, 32'h00010000}, {32'd0, 32'd255, 32'd0}, 1'b0);
        run({32'h00C80000, 32'h00000000, 32'h00008000}, {32'd128, 32'd128, 32'd128}, 1'b0);
        run({32'h00100000, 32'h00010001, 32'h00010000}, 96'd0, 1'b1);
        run({32'h01680000, 32'h00010000, 32'h00010000}, 96'd0, 1'b1);
        run({32'h00500000, 32'h00008000, 32'h00010001}, 96'd0, 1'b1);
        run({32'h001E0000, 32'h00010000, 32'h00010000}, {32'd255, 32'd128, 32'd0}, 1'b0);

        // Output holds, then tri-states without disturbing the pipeline
        repeat (3) @(posedge clk);
        #1;
        check("out_hold", out_w, {32'd255, 32'd128, 32'd0});
        enable = 1'b0;
        #1;
        z_ok = (out_w === {96{1'bz}});
        check("out_highz", {95'd0, z_ok}, 96'd1);
        run({32'h00B40000, 32'h00010000, 32'h00010000}, {32'd0, 32'd255, 32'd255}, 1'b0);
        run({32'h00100000, 32'h00000000, 32'h00020000}, 96'd0, 1'b1);
        enable = 1'b1;
        #1;
        check("out_reappears", out_w, 96'd0);
        check("error_held", {95'd0, error}, 96'd1);
        run({32'h00B40000, 32'h00010000, 32'h00010000}, {32'd0, 32'd255, 32'd255}, 1'b0);

        // Random valid inputs against the model
        for (int i = 0; i < 5; i++) begin
            start(rand_in(), 1'b0, '0, 1'b0);
            wait_done();
        end

        // Back-to-back: In_Valid held high, inputs churn while busy
        acc0     = accepts;
        use_ovr  = 1'b0;
        in_w     = rand_in();
        in_valid = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
            #1;
            rdy_exp = (i == 19) || (i == 39);
            check("b2b_ready", {95'd0, ready}, {95'd0, rdy_exp});
            in_w = rand_in();
        end
        in_valid = 1'b0;
        wait_done();
        check("b2b_accepts", 96'(accepts - acc0), 96'd3);

        // Reset mid-transaction aborts it
        start({32'h00300000, 32'h00010000, 32'h00010000}, 1'b1, 96'd0, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        aborted++;
        #1;
        check("rst_async_ready", {95'd0, ready}, 96'd1);
        check("rst_valid_out", {95'd0, valid_out}, 96'd0);
        check("rst_out", out_w, 96'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (25) @(negedge clk);
        @(posedge clk);
        #1;
        run({32'h014A0000, 32'h00010000, 32'h00010000}, {32'd255, 32'd0, 32'd128}, 1'b0);

        check("queue_drained", 96'(sb.size()), 96'd0);
        check("accept_vs_valid", 96'(accepts - aborted), 96'(valids));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
